router_pkt_tx: RTL and testbench

Packet transmitter for the 1x3 router's input port. It accepts a send request (destination address, payload length), buffers the payload from a byte source, and drives the router input protocol. The frame is a header byte {len[5:0], addr[1:0]}, then the payload bytes with pkt_valid high, then one parity byte with pkt_valid low. It honours router busy back-pressure and reports the router err flag per packet. It is used as a bench/host-side stimulus engine and as the upstream stage in chained router fabrics.

---
 rtl/router_pkt_tx_if.sv | 28 ++
 rtl/router_pkt_tx.sv | 172 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Host/router-side signal bundle for the router packet transmitter.
// The slave modport is the transmitter's view; master is the driver/bench view.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       start_ready;
    logic       reject;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic       err;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       done;
    logic       pkt_err;

    modport slave (
        input  start, addr, len, src_data, src_valid, busy, err,
        output start_ready, reject, src_ready, data_out, pkt_valid, done, pkt_err
    );

    modport master (
        output start, addr, len, src_data, src_valid, busy, err,
        input  start_ready, reject, src_ready, data_out, pkt_valid, done, pkt_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a payload, then sends
// header / payload / parity under busy back-pressure and checks err afterwards.
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic            clock,
    input  logic            reset,
    router_pkt_tx_if.slave  bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int WW = $clog2(ERR_WAIT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_ERR_CHK = 3'd5;

    logic [2:0]    state_q,   state_d;
    logic [1:0]    addr_q,    addr_d;
    logic [5:0]    len_q,     len_d;
    logic [6:0]    wr_cnt_q,  wr_cnt_d;
    logic [6:0]    rd_cnt_q,  rd_cnt_d;
    logic [7:0]    par_q,     par_d;
    logic [7:0]    data_q,    data_d;
    logic          pv_q,      pv_d;
    logic          done_q,    done_d;
    logic          reject_q,  reject_d;
    logic          pkt_err_q, pkt_err_d;
    logic [WW-1:0] wait_q,    wait_d;

    logic [7:0]    buf_q [0:MAX_LEN-1];
    logic          buf_we;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          xfer;
    logic [6:0]    len_ext;

    assign xfer    = !bus.busy;
    assign len_ext = {1'b0, len_q};
    // Header beat always precedes buffer[0]; counters are cleared on start.
    assign rd_addr = (state_q == S_HEADER) ? '0 : rd_cnt_q[AW-1:0];
    assign rd_data = buf_q[rd_addr];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        par_d     = par_q;
        data_d    = data_q;
        pv_d      = pv_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        pkt_err_d = pkt_err_q;
        wait_d    = wait_q;
        buf_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.addr != 2'd3 && bus.len != 6'd0) begin
                        addr_d    = bus.addr;
                        len_d     = bus.len;
                        pkt_err_d = 1'b0;
                        par_d     = 8'd0;
                        wr_cnt_d  = 7'd0;
                        rd_cnt_d  = 7'd0;
                        state_d   = S_LOAD;
                    end else begin
                        reject_d  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.src_valid) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 7'd1;
                    par_d    = par_q ^ bus.src_data;
                    // Header goes out on the same edge the last byte lands.
                    if (wr_cnt_q == len_ext - 7'd1) begin
                        data_d  = {len_q, addr_q};
                        pv_d    = 1'b1;
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    data_d   = rd_data;
                    rd_cnt_d = 7'd1;
                    par_d    = par_q ^ data_q;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    if (rd_cnt_q < len_ext) begin
                        data_d   = rd_data;
                        rd_cnt_d = rd_cnt_q + 7'd1;
                    end else begin
                        data_d   = par_q;
                        pv_d     = 1'b0;
                        state_d  = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (xfer) begin
                    data_d  = 8'd0;
                    wait_d  = '0;
                    state_d = S_ERR_CHK;
                end
            end
            S_ERR_CHK: begin
                if (bus.err) pkt_err_d = 1'b1;
                wait_d = wait_q + 1'b1;
                if (wait_q == WW'(ERR_WAIT - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 2'd0;
            len_q     <= 6'd0;
            wr_cnt_q  <= 7'd0;
            rd_cnt_q  <= 7'd0;
            par_q     <= 8'd0;
            data_q    <= 8'd0;
            pv_q      <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
            pkt_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            par_q     <= par_d;
            data_q    <= data_d;
            pv_q      <= pv_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
            pkt_err_q <= pkt_err_d;
            wait_q    <= wait_d;
        end
    end

    // Payload store carries no reset; its contents are only read after a full load.
    always_ff @(posedge clock) begin
        if (buf_we) buf_q[wr_cnt_q[AW-1:0]] <= bus.src_data;
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.src_ready   = (state_q == S_LOAD);
    assign bus.data_out    = data_q;
    assign bus.pkt_valid   = pv_q;
    assign bus.done        = done_q;
    assign bus.reject      = reject_q;
    assign bus.pkt_err     = pkt_err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed + randomized bench for router_pkt_tx against a frame-level reference model.
module tb_router_pkt_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] pl [0:63];

    router_pkt_tx_if bus();

    router_pkt_tx #(.MAX_LEN(63), .ERR_WAIT(3)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one packet; the model is the expected byte stream {hdr, payload, xor}.
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input int busy_pct,
                            input int src_pct, input int busy_k, input int err_m,
                            input int err_pct, input int abort_k);
        logic [7:0] exp_q[$];
        logic [7:0] par;
        logic       exp_err, bz, sv;
        int         wr, k, held, m, cyc, phase;
        exp_q.push_back({l, a});
        par = {l, a};
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(pl[i]);
            par ^= pl[i];
        end
        exp_q.push_back(par);
        wr = 0; k = 0; held = 0; m = 0; cyc = 0; phase = 0; exp_err = 1'b0;

        chk("start_ready_idle", {31'd0, bus.start_ready}, 1);
        bus.start = 1'b1; bus.addr = a; bus.len = l;
        @(negedge clk);
        bus.start = 1'b0;
        chk("pkt_err_cleared", {31'd0, bus.pkt_err}, 0);
        chk("start_ready_low", {31'd0, bus.start_ready}, 0);

        while (1) begin
            cyc++;
            if (cyc > 3000) begin
                checks++; failures++;
                $error("FAIL timeout observed=phase%0d expected=packet_complete", phase);
                break;
            end
            if (phase == 0 && bus.pkt_valid) phase = 1;
            if (phase == 0) begin
                chk("src_ready_load", {31'd0, bus.src_ready}, 1);
                sv = ($urandom_range(99) < src_pct);
                bus.src_valid = sv;
                bus.src_data  = pl[wr];
                bus.busy      = 1'($urandom_range(1));
                @(negedge clk);
                if (sv) wr++;
            end else if (phase == 1) begin
                bus.src_valid = 1'b0;
                chk("data_out", {24'd0, bus.data_out}, {24'd0, exp_q[k]});
                chk("pkt_valid", {31'd0, bus.pkt_valid}, (k < exp_q.size() - 1) ? 1 : 0);
                chk("src_ready_tx", {31'd0, bus.src_ready}, 0);
                chk("reject_tx", {31'd0, bus.reject}, 0);
                if (k == abort_k) begin
                    #2 rst = 1'b1;
                    #1;
                    chk("rst_data_out", {24'd0, bus.data_out}, 0);
                    chk("rst_pkt_valid", {31'd0, bus.pkt_valid}, 0);
                    chk("rst_start_ready", {31'd0, bus.start_ready}, 1);
                    chk("rst_pkt_err", {31'd0, bus.pkt_err}, 0);
                    bus.busy = 1'b0; bus.start = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    return;
                end
                bz = (k == busy_k && held < 2) ? 1'b1 : ($urandom_range(99) < busy_pct);
                if (k == busy_k && held < 2) held++;
                bus.busy  = bz;
                bus.start = 1'($urandom_range(1));
                bus.addr  = 2'($urandom_range(3));
                bus.len   = 6'($urandom);
                @(negedge clk);
                if (!bz) k++;
                if (k == exp_q.size()) begin
                    phase = 2; bus.start = 1'b0; bus.busy = 1'b0;
                end
            end else begin
                m++;
                chk("done", {31'd0, bus.done}, (m == 4) ? 1 : 0);
                if (m == 4) begin
                    chk("pkt_err_at_done", {31'd0, bus.pkt_err}, {31'd0, exp_err});
                    chk("data_out_idle", {24'd0, bus.data_out}, 0);
                    chk("pkt_valid_idle", {31'd0, bus.pkt_valid}, 0);
                end
                if (m == 5) begin
                    chk("start_ready_after", {31'd0, bus.start_ready}, 1);
                    chk("pkt_err_hold", {31'd0, bus.pkt_err}, {31'd0, exp_err});
                    bus.err = 1'b0;
                    break;
                end
                bus.err = (m == err_m) || ($urandom_range(99) < err_pct);
                if (m <= 3) exp_err = exp_err | bus.err;
                @(negedge clk);
            end
        end
        bus.err = 1'b0;
    endtask

    task automatic illegal_req(input logic [1:0] a, input logic [5:0] l);
        bus.start = 1'b1; bus.addr = a; bus.len = l;
        @(negedge clk);
        bus.start = 1'b0;
        chk("reject_pulse", {31'd0, bus.reject}, 1);
        chk("reject_start_ready", {31'd0, bus.start_ready}, 1);
        chk("reject_pkt_valid", {31'd0, bus.pkt_valid}, 0);
        @(negedge clk);
        chk("reject_clear", {31'd0, bus.reject}, 0);
        chk("reject_src_ready", {31'd0, bus.src_ready}, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.addr = 2'd0; bus.len = 6'd0;
        bus.src_data = 8'd0; bus.src_valid = 1'b0; bus.busy = 1'b0; bus.err = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_data_out", {24'd0, bus.data_out}, 0);
        chk("reset_pkt_valid", {31'd0, bus.pkt_valid}, 0);
        chk("reset_done", {31'd0, bus.done}, 0);
        chk("reset_reject", {31'd0, bus.reject}, 0);
        chk("reset_pkt_err", {31'd0, bus.pkt_err}, 0);
        chk("reset_start_ready", {31'd0, bus.start_ready}, 1);
        chk("reset_src_ready", {31'd0, bus.src_ready}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic three-byte packet, then the same under a 2-cycle stall on byte 0x22.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 0, 100, -1, 0, 0, -1);
        send_pkt(2'd1, 6'd3, 0, 100, 2, 0, 0, -1);

        illegal_req(2'd3, 6'd5);
        illegal_req(2'd0, 6'd0);

        // Full-length packet with a gappy source.
        for (int i = 0; i < 63; i++) pl[i] = 8'(i);
        send_pkt(2'd2, 6'd63, 0, 50, -1, 0, 0, -1);

        // err one cycle after parity, then a clean packet clears pkt_err on start.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 0, 100, -1, 2, 0, -1);
        send_pkt(2'd0, 6'd3, 0, 100, -1, 0, 0, -1);

        // Reset mid-payload, then a single-byte packet.
        for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
        send_pkt(2'd1, 6'd5, 0, 100, -1, 0, 0, 2);
        pl[0] = 8'($urandom);
        send_pkt(2'd2, 6'd1, 0, 100, -1, 0, 0, -1);

        for (int n = 0; n < 10; n++) begin
            logic [5:0] rl;
            rl = 6'($urandom_range(63, 1));
            for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
            send_pkt(2'($urandom_range(2)), rl, 30, 60, -1, 0, 10, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
